// File: rtl/wb_pkg.sv
// ---------------------------------------------------------------------------
// wb_pkg
//   Shared definitions for the writeback arbiter slice: architectural
//   constants, the buffered write request record and the state encoding of
//   the long-latency holding FIFO.
// ---------------------------------------------------------------------------
package wb_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned NREG       = 32;
    localparam int unsigned REG_ADDR_W = 5;

    // One pending register-file write.
    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_req_t;

    // Occupancy of the holding FIFO; the only source of "how many entries".
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } wb_fifo_state_e;

endpackage

// File: rtl/wb_skid_fifo.sv
// ---------------------------------------------------------------------------
// wb_skid_fifo
//   Two-entry in-order holding buffer for long-latency results that lost the
//   write-port slot. Each entry carries a kill bit so a younger pipeline write
//   to the same register can retire it without a register-file update.
//
// Ports
//   clk, rst      : clock, asynchronous active-high reset
//   push/push_req : enqueue a request at the tail (never asserted when FULL)
//   pop           : retire the head (never asserted when EMPTY)
//   kill_valid    : mark every live entry whose rd equals kill_rd as killed
//   kill_rd       : register being overwritten by the pipeline this cycle
//   head          : current head request
//   head_killed   : kill bit of the head entry
//   state         : EMPTY / ONE / FULL occupancy
//   live_mask     : one-hot OR of rd over live, non-killed, non-x0 entries
// ---------------------------------------------------------------------------
module wb_skid_fifo
    import wb_pkg::*;
#(
    parameter int unsigned NREG       = wb_pkg::NREG,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  wb_req_t               push_req,
    input  logic                  pop,
    input  logic                  kill_valid,
    input  logic [REG_ADDR_W-1:0] kill_rd,
    output wb_req_t               head,
    output logic                  head_killed,
    output wb_fifo_state_e        state,
    output logic [NREG-1:0]       live_mask
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    wb_req_t               mem [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] kill;
    logic [FIFO_DEPTH-1:0] slot_valid;
    logic [PTR_W-1:0]      rptr;
    logic [PTR_W-1:0]      wptr;
    wb_fifo_state_e        state_q;
    wb_fifo_state_e        state_d;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: push-only advances, pop-only retreats, both or neither hold.
    always_comb begin
        state_d = state_q;
        if (push && !pop) begin
            case (state_q)
                EMPTY:   state_d = ONE;
                ONE:     state_d = FULL;
                default: state_d = state_q;
            endcase
        end else if (pop && !push) begin
            case (state_q)
                FULL:    state_d = ONE;
                ONE:     state_d = EMPTY;
                default: state_d = state_q;
            endcase
        end
    end

    // Which physical slots hold an entry; occupancy comes from state, the
    // pointers only say where.
    always_comb begin
        slot_valid = '0;
        for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
            slot_valid[i] = (state_q == FULL) ||
                            ((state_q == ONE) && (rptr == PTR_W'(i)));
        end
    end

    // Pointers and kill bits. A freshly pushed slot starts un-killed; the
    // caller drops a same-cycle push that would be killed before it arrives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rptr <= '0;
            wptr <= '0;
            kill <= '0;
        end else begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                if (kill_valid && slot_valid[i] && (mem[i].rd == kill_rd)) begin
                    kill[i] <= 1'b1;
                end
            end
            if (push) begin
                kill[wptr] <= 1'b0;
                wptr       <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
        end
    end

    // Payload storage needs no reset: slot_valid gates every use of it.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= push_req;
        end
    end

    always_comb begin
        live_mask = '0;
        for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
            if (slot_valid[i] && !kill[i] && (mem[i].rd != '0)) begin
                live_mask[mem[i].rd] = 1'b1;
            end
        end
    end

    assign head        = mem[rptr];
    assign head_killed = kill[rptr];
    assign state       = state_q;

endmodule

// File: rtl/wb_write_arbiter.sv
// ---------------------------------------------------------------------------
// wb_write_arbiter
//   Merges the in-order pipeline WB result and a long-latency unit result onto
//   the single register-file write port. Pipeline writes always win; buffered
//   long-latency results drain in order when the pipeline is idle; with an
//   empty buffer an accepted long-latency result bypasses straight through.
//   Writes to x0 are suppressed, and buffered writes overtaken by a younger
//   pipeline write to the same register are killed.
//
// Ports
//   clk, rst                 : clock, asynchronous active-high reset
//   wb_valid/wb_rd/wb_data   : pipeline result (cannot be stalled)
//   lu_valid/lu_rd/lu_data   : long-latency result offer
//   lu_ready                 : long-latency result accepted this cycle
//   reg_we/reg_waddr/reg_wdata : registered register-file write port
//   pending_mask             : bit r set while a live buffered write to r exists
// ---------------------------------------------------------------------------
module wb_write_arbiter
    import wb_pkg::*;
#(
    parameter int unsigned XLEN       = wb_pkg::XLEN,
    parameter int unsigned NREG       = wb_pkg::NREG,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wb_valid,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic [XLEN-1:0]       wb_data,
    input  logic                  lu_valid,
    output logic                  lu_ready,
    input  logic [REG_ADDR_W-1:0] lu_rd,
    input  logic [XLEN-1:0]       lu_data,
    output logic                  reg_we,
    output logic [REG_ADDR_W-1:0] reg_waddr,
    output logic [XLEN-1:0]       reg_wdata,
    output logic [NREG-1:0]       pending_mask
);

    wb_fifo_state_e        fifo_state;
    wb_req_t               head;
    wb_req_t               push_req;
    logic                  head_killed;
    logic                  push;
    logic                  pop;
    logic                  lu_acc;
    logic                  lu_drop;
    logic                  we_d;
    logic [REG_ADDR_W-1:0] waddr_d;
    logic [XLEN-1:0]       wdata_d;

    wb_skid_fifo #(
        .NREG       (NREG),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push        (push),
        .push_req    (push_req),
        .pop         (pop),
        .kill_valid  (wb_valid),
        .kill_rd     (wb_rd),
        .head        (head),
        .head_killed (head_killed),
        .state       (fifo_state),
        .live_mask   (pending_mask)
    );

    // Grant and filtering. lu_ready depends only on FIFO state (and reset),
    // never on lu_valid, so the producer sees no combinational loop.
    always_comb begin
        lu_ready = !rst && (fifo_state != FULL);
        lu_acc   = lu_valid && lu_ready;
        // x0 results and results already superseded by this cycle's pipeline
        // write are dropped at accept and never occupy a slot.
        lu_drop  = (lu_rd == '0) || (wb_valid && (wb_rd == lu_rd));
        push_req = '{rd: lu_rd, data: lu_data};
        push     = 1'b0;
        pop      = 1'b0;
        we_d     = 1'b0;
        waddr_d  = wb_rd;
        wdata_d  = wb_data;

        if (wb_valid) begin
            we_d = (wb_rd != '0);
            push = lu_acc && !lu_drop;
        end else if (fifo_state != EMPTY) begin
            pop     = 1'b1;
            we_d    = !head_killed && (head.rd != '0);
            waddr_d = head.rd;
            wdata_d = head.data;
            push    = lu_acc && !lu_drop;
        end else if (lu_acc) begin
            we_d    = (lu_rd != '0);
            waddr_d = lu_rd;
            wdata_d = lu_data;
        end
    end

    // Output registers; address/data only move on a real write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reg_we    <= 1'b0;
            reg_waddr <= '0;
            reg_wdata <= '0;
        end else begin
            reg_we <= we_d;
            if (we_d) begin
                reg_waddr <= waddr_d;
                reg_wdata <= wdata_d;
            end
        end
    end

endmodule

// File: tb/tb_wb_write_arbiter.sv
module tb_wb_write_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        lu_valid;
    logic        lu_ready;
    logic [4:0]  lu_rd;
    logic [31:0] lu_data;
    logic        reg_we;
    logic [4:0]  reg_waddr;
    logic [31:0] reg_wdata;
    logic [31:0] pending_mask;

    int n_pass  = 0;
    int n_total = 0;

    wb_write_arbiter #(
        .XLEN       (32),
        .NREG       (32),
        .FIFO_DEPTH (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .lu_valid     (lu_valid),
        .lu_ready     (lu_ready),
        .lu_rd        (lu_rd),
        .lu_data      (lu_data),
        .reg_we       (reg_we),
        .reg_waddr    (reg_waddr),
        .reg_wdata    (reg_wdata),
        .pending_mask (pending_mask)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wv;
        logic [4:0]  wrd;
        logic [31:0] wd;
        logic        lv;
        logic [4:0]  lrd;
        logic [31:0] ld;
        logic        rdy;   // lu_ready during the cycle
        logic        we;    // registered write produced by this cycle's grant
        logic [4:0]  wa;
        logic [31:0] wdat;
        logic [31:0] pm;    // pending_mask after the edge
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic wv, input logic [4:0] wrd, input logic [31:0] wd,
                                input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                                input logic rdy, input logic we, input logic [4:0] wa,
                                input logic [31:0] wdat, input logic [31:0] pm);
        vec_t v;
        v.wv = wv; v.wrd = wrd; v.wd = wd; v.lv = lv; v.lrd = lrd; v.ld = ld;
        v.rdy = rdy; v.we = we; v.wa = wa; v.wdat = wdat; v.pm = pm;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic drive(input logic wv, input logic [4:0] wrd, input logic [31:0] wd,
                         input logic lv, input logic [4:0] lrd, input logic [31:0] ld);
        wb_valid = wv; wb_rd = wrd; wb_data = wd;
        lu_valid = lv; lu_rd = lrd; lu_data = ld;
    endtask

    logic [31:0] gold [32];
    logic [31:0] img  [32];
    int          occ;
    int          x0_writes;
    logic        acc;
    logic        drop;
    logic [31:0] uniq;

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        #2;
        chk("rst_we",    reg_we,       0);
        chk("rst_waddr", reg_waddr,    0);
        chk("rst_wdata", reg_wdata,    0);
        chk("rst_ready", lu_ready,     0);
        chk("rst_pmask", pending_mask, 0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        // wv wrd wd | lv lrd ld | rdy we wa wdat pm
        vecs.push_back(mk(0, 0,  0,      1, 5,  32'hDEADBEEF, 1, 1, 5,  32'hDEADBEEF, 0));        // bypass
        vecs.push_back(mk(0, 0,  0,      0, 0,  0,            1, 0, 0,  0,            0));
        vecs.push_back(mk(1, 1,  'h100,  1, 3,  'h33,         1, 1, 1,  'h100,        'h8));      // fill
        vecs.push_back(mk(1, 2,  'h200,  1, 4,  'h44,         1, 1, 2,  'h200,        'h18));
        vecs.push_back(mk(1, 6,  'h600,  1, 7,  'h77,         0, 1, 6,  'h600,        'h18));     // full
        vecs.push_back(mk(0, 0,  0,      1, 7,  'h77,         0, 1, 3,  'h33,         'h10));     // drain r3
        vecs.push_back(mk(0, 0,  0,      1, 7,  'h77,         1, 1, 4,  'h44,         'h80));     // r4, push r7
        vecs.push_back(mk(0, 0,  0,      0, 0,  0,            1, 1, 7,  'h77,         0));        // r7
        vecs.push_back(mk(1, 8,  'h800,  1, 9,  'h99,         1, 1, 8,  'h800,        'h200));    // buffer r9
        vecs.push_back(mk(1, 9,  'h11,   0, 0,  0,            1, 1, 9,  'h11,         0));        // kill r9
        vecs.push_back(mk(0, 0,  0,      0, 0,  0,            1, 0, 0,  0,            0));        // silent pop
        vecs.push_back(mk(0, 0,  0,      0, 0,  0,            1, 0, 0,  0,            0));
        vecs.push_back(mk(1, 10, 'hA0,   1, 10, 'hBAD,        1, 1, 10, 'hA0,         0));        // same-cycle kill
        vecs.push_back(mk(0, 0,  0,      0, 0,  0,            1, 0, 0,  0,            0));
        vecs.push_back(mk(1, 11, 'hB,    1, 0,  'hC,          1, 1, 11, 'hB,          0));        // lu x0
        vecs.push_back(mk(0, 0,  0,      0, 0,  0,            1, 0, 0,  0,            0));
        vecs.push_back(mk(1, 0,  'h55,   0, 0,  0,            1, 0, 0,  0,            0));        // wb x0
        vecs.push_back(mk(0, 0,  0,      1, 0,  'h66,         1, 0, 0,  0,            0));        // bypass x0
        vecs.push_back(mk(1, 12, 'hC0,   1, 13, 'hD0,         1, 1, 12, 'hC0,         'h2000));
        vecs.push_back(mk(1, 14, 'hE0,   1, 15, 'hF0,         1, 1, 14, 'hE0,         'hA000));   // wb+acc+nonempty
        vecs.push_back(mk(0, 0,  0,      0, 0,  0,            0, 1, 13, 'hD0,         'h8000));
        vecs.push_back(mk(0, 0,  0,      1, 16, 'h160,        1, 1, 15, 'hF0,         'h10000));  // pop+push
        vecs.push_back(mk(0, 0,  0,      0, 0,  0,            1, 1, 16, 'h160,        0));

        foreach (vecs[i]) begin
            drive(vecs[i].wv, vecs[i].wrd, vecs[i].wd, vecs[i].lv, vecs[i].lrd, vecs[i].ld);
            #3;
            chk($sformatf("v%0d_ready", i), lu_ready, vecs[i].rdy);
            @(posedge clk); #1;
            chk($sformatf("v%0d_we", i), reg_we, vecs[i].we);
            if (vecs[i].we) begin
                chk($sformatf("v%0d_waddr", i), reg_waddr, vecs[i].wa);
                chk($sformatf("v%0d_wdata", i), reg_wdata, vecs[i].wdat);
            end
            chk($sformatf("v%0d_pmask", i), pending_mask, vecs[i].pm);
        end

        // Reset with two entries buffered.
        drive(1, 1, 'h1, 1, 20, 'h20);
        @(posedge clk); #1;
        drive(1, 2, 'h2, 1, 21, 'h21);
        @(posedge clk); #1;
        chk("prerst_pmask", pending_mask, 32'h0030_0000);
        chk("prerst_we", reg_we, 1);
        drive(0, 0, 0, 0, 0, 0);
        #2 rst = 1'b1;
        #1;
        chk("midrst_we",    reg_we,       0);
        chk("midrst_waddr", reg_waddr,    0);
        chk("midrst_wdata", reg_wdata,    0);
        chk("midrst_ready", lu_ready,     0);
        chk("midrst_pmask", pending_mask, 0);
        @(posedge clk); #1;
        chk("midrst_we2", reg_we, 0);
        rst = 1'b0;
        #1;
        chk("postrst_ready", lu_ready, 1);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            chk($sformatf("postrst_we%0d", c), reg_we, 0);
            chk($sformatf("postrst_pmask%0d", c), pending_mask, 0);
        end

        // Random: golden image is the last write in program order, where an
        // lu result accepted in a cycle precedes that cycle's pipeline write.
        for (int r = 0; r < 32; r++) begin
            gold[r] = '0;
            img[r]  = '0;
        end
        occ       = 0;
        x0_writes = 0;
        uniq      = 32'h1000;
        drive(0, 0, 0, 0, 0, 0);
        for (int c = 0; c < 400; c++) begin
            wb_valid = ($urandom_range(0, 1) == 1);
            wb_rd    = 5'($urandom_range(0, 7));
            wb_data  = uniq; uniq++;
            if (!lu_valid) begin
                lu_valid = ($urandom_range(0, 2) != 0);
                lu_rd    = 5'($urandom_range(0, 7));
                lu_data  = uniq; uniq++;
            end
            #3;
            chk("rnd_ready", lu_ready, (occ < 2) ? 1 : 0);
            acc  = lu_valid && lu_ready;
            drop = (lu_rd == 0) || (wb_valid && (wb_rd == lu_rd));
            if (acc && lu_rd != 0) gold[lu_rd] = lu_data;
            if (wb_valid && wb_rd != 0) gold[wb_rd] = wb_data;
            if (wb_valid) occ = occ + ((acc && !drop) ? 1 : 0);
            else if (occ > 0) occ = occ - 1 + ((acc && !drop) ? 1 : 0);
            @(posedge clk); #1;
            if (reg_we) begin
                img[reg_waddr] = reg_wdata;
                if (reg_waddr == 0) x0_writes++;
            end
            if (acc) lu_valid = 1'b0;
        end
        drive(0, 0, 0, 0, 0, 0);
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            if (reg_we) begin
                img[reg_waddr] = reg_wdata;
                if (reg_waddr == 0) x0_writes++;
            end
        end
        for (int r = 1; r < 32; r++) chk($sformatf("rnd_reg%0d", r), img[r], gold[r]);
        chk("rnd_x0_writes", x0_writes, 0);
        chk("rnd_drained_pmask", pending_mask, 0);
        chk("rnd_drained_ready", lu_ready, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/wb_write_arbiter.md
# wb_write_arbiter

- Writeback-side producer of the register-file write port. It merges two result sources onto the single write port: the in-order pipeline's WB result and a long-latency unit's valid/ready result.
- Long-latency results are buffered in a 2-entry FIFO. Writes to x0 are filtered, and buffered writes superseded by younger pipeline writes are killed.
- Registered outputs `reg_we`/`reg_waddr`/`reg_wdata` feed the register file and the ID-stage same-cycle write bypass. `pending_mask` feeds hazard detection.

## Interface
- `XLEN`, 32, data width
- `NREG`, 32, architectural registers; address width is $clog2(NREG)
- `FIFO_DEPTH`, 2, long-latency holding entries (fixed at 2; other values unsupported)
- `clk` in 1: single clock; all state on rising edge
- `rst` in 1: reset, asynchronous and active-high
- `wb_valid` in 1: pipeline WB result present this cycle (cannot be stalled)
- `wb_rd` in 5: pipeline destination register
- `wb_data` in XLEN: pipeline result
- `lu_valid` in 1: long-latency result offered
- `lu_ready` out 1: arbiter accepts the `lu_*` result this cycle
- `lu_rd` in 5: long-latency destination
- `lu_data` in XLEN: long-latency result
- `reg_we` out 1: register-file write enable (registered)
- `reg_waddr` out 5: write address (registered)
- `reg_wdata` out XLEN: write data (registered)
- `pending_mask` out NREG: bit r = a live buffered write to r exists

## Operation
- Accept: the `lu` result is accepted when `lu_valid && lu_ready`. `lu_ready` = FIFO not FULL, combinational from state only, never from `lu_valid`.
- FIFO state machine, with states EMPTY, ONE, FULL:
  - push-only advances one state; pop-only retreats one state.
  - push+pop holds the state.
  - Push in FULL is impossible because `lu_ready`=0.
- Slot grant each cycle, in priority order:
  1. `wb_valid`: the pipeline write wins.
  2. Otherwise, if the FIFO is non-empty: pop the head.
  3. Otherwise, if an `lu` result is accepted this cycle: bypass it straight to the output without enqueueing; state stays EMPTY.
- Accepted `lu` results that lose the slot are enqueued at the tail.
- x0 filter: any granted write with rd==0 produces `reg_we`=0 but still consumes the slot/pop. An accepted `lu` with rd==0 is dropped on accept and never enqueued.
- WAW kill: ordering contract is that any long-latency result is older than a same-cycle or later pipeline write to the same rd.
  - When `wb_valid` with `wb_rd`=r, every live FIFO entry with rd==r is marked killed.
  - An `lu` result accepted in that same cycle with `lu_rd`==r is dropped.
  - A killed head is popped silently when selected (`reg_we`=0 that cycle, slot consumed).
- `pending_mask`: OR of one-hot(rd) over live, non-killed entries, excluding x0. It is combinational from the current state and reflects the kill in the cycle after `wb_valid`.
- Arithmetic: FIFO pointers are 1-bit and wrap modulo 2. Occupancy is derived from state, never from pointer difference.

## Timing
- Latency: a grant in cycle N produces `reg_we`/`reg_waddr`/`reg_wdata` in cycle N+1, valid for exactly one cycle.
- Throughput: one register write per cycle. The FIFO drains at one entry per cycle in which `wb_valid`=0.
- Reset values:
  - `reg_we`=0, `reg_waddr`=0, `reg_wdata`=0
  - `lu_ready`=0 while `rst` is high, 1 from the first cycle after deassertion
  - `pending_mask`=0
  - state EMPTY; all kill bits clear
- Reset mid-operation: buffered entries are discarded and no write is issued for them.
- Simultaneous `wb_valid` + `lu` accept + non-empty FIFO: the pipeline write is granted, the `lu` result is enqueued, and no pop occurs.
- FULL with `wb_valid`=0: pop the head. `lu_ready` stays 0 this cycle, because it is based on current state, and rises next cycle.
- `lu_valid` with `lu_ready`=0: the source holds its payload stable until accepted. The arbiter never samples it.

## Structure
- Shared package `wb_pkg`:
  - `XLEN`, `NREG`, `REG_ADDR_W`=5 constants
  - typedef `wb_req_t` {rd, data}
  - typedef `wb_fifo_state_e` {EMPTY, ONE, FULL}
- Sub-module `wb_skid_fifo`: the 2-entry FIFO holding `wb_req_t` plus a kill bit per entry. It has a kill-by-rd input and a live-entries mask output. The arbiter top contains grant, filtering and output registers.

## Test plan
- Reset: assert `rst` mid-stream with 2 entries buffered. Required: all outputs 0 and `lu_ready`=0 during reset; after release, `lu_ready`=1 and no write issued for the discarded entries.
- Bypass: FIFO empty, `wb_valid`=0, `lu` (rd=5, 0xDEADBEEF) accepted at N. Required: `reg_we`=1, `reg_waddr`=5, `reg_wdata`=0xDEADBEEF at N+1; `pending_mask`=0 throughout.
- Fill/drain: `wb_valid`=1 for 3 cycles while `lu` offers rd=3, then rd=4, then rd=7.
  - rd=3 and rd=4 enqueue; `lu_ready`=0 on the third cycle; `pending_mask`=0x18.
  - After `wb_valid` drops: writes to r3, r4, then r7 on consecutive cycles.
- WAW kill: rd=9 buffered, then `wb_valid` with `wb_rd`=9 (0x11). Required: r9 is written 0x11 only; the killed entry later pops with `reg_we`=0; `pending_mask` bit 9 clears one cycle after the `wb_valid`.
- x0: `lu` with rd=0 while `wb_valid` is busy gives no enqueue and `pending_mask`=0. `wb_valid` with `wb_rd`=0 gives `reg_we`=0 in the following cycle.
- Random: both sources random, with a checker comparing the register-file image against a golden in-order model. Required: no lost or duplicated writes, and `lu_ready` never 1 in FULL.
